fisr_core: RTL and testbench

- Datapath stage directly downstream of the fisr_controller_v2 AXI4-Lite register file.
- Consumes the operand word and start strobe written by software, then computes y ≈ 1/sqrt(x) for IEEE-754 single-precision x.
- Method: magic-constant seed followed by ITERATIONS Newton-Raphson steps.
- Result and status feed back into read-only registers of the register file.

---
 rtl/fisr_pkg.sv | 49 ++++
 rtl/fisr_if.sv | 12 +
 rtl/fisr_fmul.sv | 38 +++
 rtl/fisr_core.sv | 177 +++++++++++++++++
 tb/tb_fisr_core.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fisr_pkg.sv
// Shared types, constants and float field helpers for the fast inverse square root stage.
package fisr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_MUL_A,
    S_MUL_B,
    S_SUB,
    S_MUL_C,
    S_SPECIAL,
    S_DONE
  } fisr_state_e;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h5F3759DF;
  localparam logic [31:0] QNAN          = 32'h7FC00000;
  localparam logic [31:0] PINF          = 32'h7F800000;
  localparam logic [31:0] FMAX          = 32'h7F7FFFFF;
  localparam logic [31:0] ONE_P5_Q230   = 32'h6000_0000;

  function automatic logic f_sign(input logic [31:0] f);
    return 1'(f >> 31);
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] f);
    return 8'(f >> 23);
  endfunction

  function automatic logic [22:0] f_frac(input logic [31:0] f);
    return 23'(f);
  endfunction

  function automatic logic [23:0] f_mant(input logic [31:0] f);
    return {1'b1, 23'(f)};
  endfunction

  // Zero/denormal, inf/NaN and any negative operand bypass the Newton path.
  function automatic logic is_special(input logic [31:0] f);
    return (f_exp(f) == 8'd0) || (f_exp(f) == 8'hFF) || f_sign(f);
  endfunction

  function automatic logic [31:0] special_result(input logic [31:0] f);
    if (f_exp(f) == 8'd0) return PINF;
    if ((f_exp(f) == 8'hFF) && (f_frac(f) != 23'd0)) return QNAN;
    if (f_sign(f)) return QNAN;
    return 32'd0;
  endfunction

endpackage

// File: rtl/fisr_if.sv
// Request/result bundle between the register file and the fisr datapath.
interface fisr_if;
  logic        start;
  logic [31:0] x_in;
  logic        busy;
  logic        done;
  logic [31:0] y_out;
  logic        special;

  modport master (output start, x_in, input busy, done, y_out, special);
  modport slave  (input start, x_in, output busy, done, y_out, special);
endinterface

// File: rtl/fisr_fmul.sv
// Single-precision multiply, truncating, result registered one cycle after operands.
// Zero/underflow flush to +0; overflow saturates to the largest finite value.
module fisr_fmul
  import fisr_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic [47:0]       prod;
  logic signed [9:0] exp_s;
  logic [22:0]       frac;
  logic [31:0]       p_d, p_q;

  always_comb begin
    prod  = {24'd0, f_mant(a_i)} * {24'd0, f_mant(b_i)};
    exp_s = $signed({2'b00, f_exp(a_i)}) + $signed({2'b00, f_exp(b_i)})
            - 10'sd127 + $signed({9'd0, prod[47]});
    frac  = prod[47] ? 23'(prod >> 24) : 23'(prod >> 23);
    p_d   = {f_sign(a_i) ^ f_sign(b_i), exp_s[7:0], frac};
    if ((f_exp(a_i) == 8'd0) || (f_exp(b_i) == 8'd0) || (exp_s <= 10'sd0)) begin
      p_d = 32'd0;
    end else if (exp_s >= 10'sd255) begin
      p_d = FMAX;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) p_q <= '0;
    else          p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/fisr_core.sv
// Fast inverse square root: magic-constant seed plus ITERATIONS Newton steps,
// sharing one registered multiplier across the three multiply states.
//
// state     | meaning
// S_IDLE    | waiting for start; x latched on acceptance
// S_SEED    | y = MAGIC - (x >> 1), h = 0.5x
// S_MUL_A   | multiplier fed h * y
// S_MUL_B   | multiplier fed (h*y) * y
// S_SUB     | t = 1.5 - product, via Q2.30
// S_MUL_C   | multiplier fed y * t; product becomes the new y
// S_SPECIAL | fixed result for zero/denormal/negative/inf/NaN
// S_DONE    | publish y_out/special, pulse done next cycle
module fisr_core
  import fisr_pkg::*;
#(
  parameter int unsigned ITERATIONS = 1,
  parameter logic [31:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic  ACLK,
  input  logic  ARESETN,
  fisr_if.slave bus
);

  localparam logic [1:0] LAST_ITER = (ITERATIONS == 0) ? 2'd0 : 2'(ITERATIONS - 1);

  fisr_state_e state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, h_q, h_d, t_q, t_d;
  logic [1:0]  iter_q, iter_d;
  logic        spec_q, spec_d;
  logic        y_in_p_q, y_in_p_d;
  logic [31:0] y_out_q, y_out_d;
  logic        done_q, done_d;
  logic        special_q, special_d;

  logic [31:0] fm_a, fm_b, fm_p, y_cur;
  logic [7:0]  sub_exp;
  logic [31:0] sub_q, sub_r, sub_t;
  logic [4:0]  lead;

  fisr_fmul u_fmul (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .a_i     (fm_a),
    .b_i     (fm_b),
    .p_o     (fm_p)
  );

  // Right after MUL_C the new y still lives in the multiplier output register.
  assign y_cur = y_in_p_q ? fm_p : y_q;

  always_comb begin
    sub_exp = f_exp(fm_p);
    sub_q   = '0;
    if (sub_exp >= 8'd128) begin
      sub_q = '1;
    end else if (sub_exp >= 8'd120) begin
      sub_q = {8'd0, f_mant(fm_p)} << (sub_exp - 8'd120);
    end else if (sub_exp != 8'd0) begin
      sub_q = {8'd0, f_mant(fm_p)} >> (8'd120 - sub_exp);
    end
    sub_r = (sub_q >= ONE_P5_Q230) ? '0 : (ONE_P5_Q230 - sub_q);
    lead  = '0;
    for (int i = 0; i < 31; i++) begin
      if (sub_r[i]) lead = 5'(i);
    end
    if (sub_r == '0) begin
      sub_t = '0;
    end else if (lead > 5'd23) begin
      sub_t = {1'b0, {3'd0, lead} + 8'd97, 23'(sub_r >> (lead - 5'd23))};
    end else begin
      sub_t = {1'b0, {3'd0, lead} + 8'd97, 23'(sub_r << (5'd23 - lead))};
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    h_d       = h_q;
    t_d       = t_q;
    iter_d    = iter_q;
    spec_d    = spec_q;
    y_in_p_d  = 1'b0;
    y_out_d   = y_out_q;
    special_d = special_q;
    done_d    = 1'b0;
    fm_a      = '0;
    fm_b      = '0;
    if (y_in_p_q) y_d = fm_p;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          spec_d  = is_special(bus.x_in);
          state_d = spec_d ? S_SPECIAL : S_SEED;
        end
      end
      S_SEED: begin
        y_d     = MAGIC - (x_q >> 1);
        h_d     = (f_exp(x_q) == 8'd1) ? 32'd0 : {x_q[31], f_exp(x_q) - 8'd1, f_frac(x_q)};
        iter_d  = '0;
        state_d = (ITERATIONS == 0) ? S_DONE : S_MUL_A;
      end
      S_MUL_A: begin
        fm_a    = h_q;
        fm_b    = y_cur;
        state_d = S_MUL_B;
      end
      S_MUL_B: begin
        fm_a    = fm_p;
        fm_b    = y_q;
        state_d = S_SUB;
      end
      S_SUB: begin
        t_d     = sub_t;
        state_d = S_MUL_C;
      end
      S_MUL_C: begin
        fm_a     = y_q;
        fm_b     = t_q;
        y_in_p_d = 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + 2'd1;
          state_d = S_MUL_A;
        end
      end
      S_SPECIAL: begin
        y_d     = special_result(x_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        y_out_d   = y_cur;
        special_d = spec_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      h_q       <= '0;
      t_q       <= '0;
      iter_q    <= '0;
      spec_q    <= 1'b0;
      y_in_p_q  <= 1'b0;
      y_out_q   <= '0;
      done_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      h_q       <= h_d;
      t_q       <= t_d;
      iter_q    <= iter_d;
      spec_q    <= spec_d;
      y_in_p_q  <= y_in_p_d;
      y_out_q   <= y_out_d;
      done_q    <= done_d;
      special_q <= special_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.y_out   = y_out_q;
  assign bus.special = special_q;

endmodule

// File: tb/tb_fisr_core.sv
// Bench for fisr_core: three instances (0, 1, 2 Newton steps) driven in lockstep,
// results checked against true 1/sqrt(x) and the seed formula.
module tb_fisr_core;

  localparam int NC = 24;
  localparam logic [31:0] MAGIC = 32'h5F3759DF;
  localparam int LAT [3] = '{2, 6, 10};
  localparam logic [31:0] NX [4] = '{32'h40800000, 32'h3F800000, 32'h41100000, 32'h3E800000};
  localparam logic [31:0] SX [9] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'hC0800000,
                                    32'hFF800000, 32'h7F800000, 32'h7FC00001, 32'h7F800001,
                                    32'hFFC00000};
  localparam logic [31:0] SY [9] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7FC00000,
                                    32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                                    32'h7FC00000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_drv = 1'b0;
  logic [31:0] x_drv = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  fisr_if bus0();
  fisr_if bus1();
  fisr_if bus2();

  assign bus0.start = st_drv;
  assign bus1.start = st_drv;
  assign bus2.start = st_drv;
  assign bus0.x_in  = x_drv;
  assign bus1.x_in  = x_drv;
  assign bus2.x_in  = x_drv;

  fisr_core #(.ITERATIONS(0)) u_it0 (.ACLK(clk), .ARESETN(rst_n), .bus(bus0));
  fisr_core #(.ITERATIONS(1)) u_it1 (.ACLK(clk), .ARESETN(rst_n), .bus(bus1));
  fisr_core #(.ITERATIONS(2)) u_it2 (.ACLK(clk), .ARESETN(rst_n), .bus(bus2));

  logic [2:0]  busy_v, done_v, sp_v;
  logic [31:0] y_v [3];
  assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
  assign done_v = {bus2.done, bus1.done, bus0.done};
  assign sp_v   = {bus2.special, bus1.special, bus0.special};
  assign y_v[0] = bus0.y_out;
  assign y_v[1] = bus1.y_out;
  assign y_v[2] = bus2.y_out;

  always #5 clk = ~clk;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          dcnt [3];
  int          dfirst [3];
  int          dlast [3];
  logic [31:0] dy_first [3];
  logic [31:0] dy_last [3];
  logic        dsp_first [3];
  logic        bsy_h [3][NC];
  logic [31:0] yo_h [3][NC];

  function automatic real f2r(input logic [31:0] f);
    int  e;
    real m;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    return (f[31] ? -1.0 : 1.0) * m * (2.0 ** real'(e - 127));
  endfunction

  function automatic real rel_err(input logic [31:0] y, input logic [31:0] x);
    real r, v;
    r = 1.0 / $sqrt(f2r(x));
    v = f2r(y);
    return (v > r) ? (v - r) / r : (r - v) / r;
  endfunction

  // Start with xa so it is accepted at edge 0; optional second start at edge c2
  // and reset sampled at edge rc. Outputs sampled after each edge k.
  task automatic run_seq(input logic [31:0] xa, input int c2, input logic [31:0] xb, input int rc);
    for (int d = 0; d < 3; d++) begin
      dcnt[d] = 0; dfirst[d] = -1; dlast[d] = -1;
      dy_first[d] = '0; dy_last[d] = '0; dsp_first[d] = 1'b0;
    end
    @(negedge clk);
    st_drv = 1'b1;
    x_drv  = xa;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        bsy_h[d][k] = busy_v[d];
        yo_h[d][k]  = y_v[d];
        if (done_v[d] === 1'b1) begin
          if (dcnt[d] == 0) begin
            dfirst[d] = k; dy_first[d] = y_v[d]; dsp_first[d] = sp_v[d];
          end
          dlast[d] = k; dy_last[d] = y_v[d]; dcnt[d]++;
        end
      end
      st_drv = (k + 1 == c2);
      if (k + 1 == c2) x_drv = xb;
      rst_n = (k + 1 != rc);
    end
    st_drv = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (busy_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got=%b want=0", d, busy_v[d]); end
      n_cmp++; if (done_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d got=%b want=0", d, done_v[d]); end
      n_cmp++; if (y_v[d] !== 32'h0) begin n_fail++; $display("FAIL reset_y dut%0d got=%h want=0", d, y_v[d]); end
      n_cmp++; if (sp_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_special dut%0d got=%b want=0", d, sp_v[d]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    real tol, e;
    for (int i = 0; i < 4; i++) begin
      run_seq(NX[i], -1, 32'h0, -1);
      for (int d = 0; d < 3; d++) begin
        n_cmp++; if (dfirst[d] !== LAT[d]) begin n_fail++; $display("FAIL normal_latency dut%0d x=%h got=%0d want=%0d", d, NX[i], dfirst[d], LAT[d]); end
        n_cmp++; if (dcnt[d] !== 1) begin n_fail++; $display("FAIL normal_done_count dut%0d x=%h got=%0d want=1", d, NX[i], dcnt[d]); end
        n_cmp++; if (dsp_first[d] !== 1'b0) begin n_fail++; $display("FAIL normal_special dut%0d x=%h got=%b want=0", d, NX[i], dsp_first[d]); end
        n_cmp++; if (bsy_h[d][0] !== 1'b1) begin n_fail++; $display("FAIL normal_busy_start dut%0d got=%b want=1", d, bsy_h[d][0]); end
        n_cmp++; if (bsy_h[d][LAT[d]] !== 1'b0) begin n_fail++; $display("FAIL normal_busy_done dut%0d got=%b want=0", d, bsy_h[d][LAT[d]]); end
      end
      n_cmp++;
      if (dy_first[0] !== MAGIC - (NX[i] >> 1)) begin
        n_fail++; $display("FAIL seed_value x=%h got=%h want=%h", NX[i], dy_first[0], MAGIC - (NX[i] >> 1));
      end
      e = rel_err(dy_first[1], NX[i]);
      n_cmp++; if (!(e < 2.0e-3)) begin n_fail++; $display("FAIL newton1 x=%h got=%h rel_err=%g want<0.002", NX[i], dy_first[1], e); end
      tol = (NX[i] == 32'h41100000) ? 5.0e-6 : 1.0e-5;
      e = rel_err(dy_first[2], NX[i]);
      n_cmp++; if (!(e < tol)) begin n_fail++; $display("FAIL newton2 x=%h got=%h rel_err=%g want<%g", NX[i], dy_first[2], e, tol); end
    end
  endtask

  task automatic test_special();
    for (int i = 0; i < 9; i++) begin
      run_seq(SX[i], -1, 32'h0, -1);
      for (int d = 0; d < 3; d++) begin
        n_cmp++; if (dfirst[d] !== 2) begin n_fail++; $display("FAIL special_latency dut%0d x=%h got=%0d want=2", d, SX[i], dfirst[d]); end
        n_cmp++; if (dy_first[d] !== SY[i]) begin n_fail++; $display("FAIL special_value dut%0d x=%h got=%h want=%h", d, SX[i], dy_first[d], SY[i]); end
        n_cmp++; if (dsp_first[d] !== 1'b1) begin n_fail++; $display("FAIL special_flag dut%0d x=%h got=%b want=1", d, SX[i], dsp_first[d]); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    real e;
    run_seq(32'h40800000, 3, 32'h41100000, -1);
    for (int d = 1; d < 3; d++) begin
      n_cmp++; if (dcnt[d] !== 1) begin n_fail++; $display("FAIL ignore_done_count dut%0d got=%0d want=1", d, dcnt[d]); end
      n_cmp++; if (dfirst[d] !== LAT[d]) begin n_fail++; $display("FAIL ignore_latency dut%0d got=%0d want=%0d", d, dfirst[d], LAT[d]); end
      n_cmp++; if (bsy_h[d][3] !== 1'b1) begin n_fail++; $display("FAIL ignore_busy dut%0d got=%b want=1", d, bsy_h[d][3]); end
      e = rel_err(dy_first[d], 32'h40800000);
      n_cmp++; if (!(e < 2.0e-3)) begin n_fail++; $display("FAIL ignore_value dut%0d got=%h rel_err=%g want<0.002 of 0.5", d, dy_first[d], e); end
    end
  endtask

  task automatic test_back_to_back();
    real e;
    run_seq(32'h40800000, 7, 32'h41100000, -1);
    n_cmp++; if (dfirst[1] !== 6) begin n_fail++; $display("FAIL b2b_first_latency got=%0d want=6", dfirst[1]); end
    n_cmp++; if (bsy_h[1][7] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b want=1", bsy_h[1][7]); end
    n_cmp++; if (dcnt[1] !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d want=2", dcnt[1]); end
    n_cmp++; if (dlast[1] !== 13) begin n_fail++; $display("FAIL b2b_second_latency got=%0d want=13", dlast[1]); end
    e = rel_err(dy_first[1], 32'h40800000);
    n_cmp++; if (!(e < 2.0e-3)) begin n_fail++; $display("FAIL b2b_first_value got=%h rel_err=%g", dy_first[1], e); end
    e = rel_err(dy_last[1], 32'h41100000);
    n_cmp++; if (!(e < 2.0e-3)) begin n_fail++; $display("FAIL b2b_second_value got=%h rel_err=%g", dy_last[1], e); end
  endtask

  task automatic test_reset_mid();
    run_seq(32'h40800000, -1, 32'h0, 3);
    for (int d = 1; d < 3; d++) begin
      n_cmp++; if (bsy_h[d][2] !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before dut%0d got=%b want=1", d, bsy_h[d][2]); end
      n_cmp++; if (bsy_h[d][3] !== 1'b0) begin n_fail++; $display("FAIL abort_busy dut%0d got=%b want=0", d, bsy_h[d][3]); end
      n_cmp++; if (yo_h[d][3] !== 32'h0) begin n_fail++; $display("FAIL abort_y dut%0d got=%h want=0", d, yo_h[d][3]); end
      n_cmp++; if (dcnt[d] !== 0) begin n_fail++; $display("FAIL abort_done_count dut%0d got=%0d want=0", d, dcnt[d]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    real e;
    for (int n = 0; n < 1000; n++) begin
      x = {1'b0, 8'($urandom_range(254, 2)), 23'($urandom)};
      run_seq(x, -1, 32'h0, -1);
      for (int d = 0; d < 3; d++) begin
        n_cmp++; if (dfirst[d] !== LAT[d]) begin n_fail++; $display("FAIL rand_latency dut%0d x=%h got=%0d want=%0d", d, x, dfirst[d], LAT[d]); end
        n_cmp++; if (dsp_first[d] !== 1'b0) begin n_fail++; $display("FAIL rand_special dut%0d x=%h got=%b want=0", d, x, dsp_first[d]); end
      end
      n_cmp++; if (dy_first[0] !== MAGIC - (x >> 1)) begin n_fail++; $display("FAIL rand_seed x=%h got=%h want=%h", x, dy_first[0], MAGIC - (x >> 1)); end
      e = rel_err(dy_first[1], x);
      n_cmp++; if (!(e < 2.0e-3)) begin n_fail++; $display("FAIL rand_newton1 x=%h got=%h rel_err=%g want<0.002", x, dy_first[1], e); end
      e = rel_err(dy_first[2], x);
      n_cmp++; if (!(e < 1.0e-5)) begin n_fail++; $display("FAIL rand_newton2 x=%h got=%h rel_err=%g want<1e-5", x, dy_first[2], e); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
